// File: rtl/sram_mem_stage_if.sv
// Pipeline-side request/response bundle for the MEM-stage SRAM port.
// master: pipeline (drives requests); slave: sram_mem_stage (answers).
interface sram_mem_stage_if #(
    parameter int DATA_W = 32
);
    logic              mem_r_en;
    logic              mem_w_en;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ready;
    logic              addr_err;

    modport master (
        output mem_r_en, mem_w_en, addr, wdata,
        input  rdata, ready, addr_err
    );

    modport slave (
        input  mem_r_en, mem_w_en, addr, wdata,
        output rdata, ready, addr_err
    );
endinterface

// File: rtl/sram_mem_stage.sv
// MEM stage front-end to an async SRAM with wait states; ready=0 freezes pipe.
// Ports: clk, rst (async, active-low), bus (slave: r/w req, addr, wdata,
// rdata, ready, addr_err), sram_addr/dq_out/dq_oe/dq_in/we_n/oe_n.
// Optional READ_BUF_EN: one-entry buffer serving repeat loads in one cycle.
module sram_mem_stage #(
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_STATES = 2,
    parameter int BASE_ADDR   = 1024,
    parameter int DEPTH       = 65536
) (
    input  logic               clk,
    input  logic               rst,
    sram_mem_stage_if.slave    bus,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);
    localparam int BEATS = DATA_W / SRAM_DW;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [BW-1:0]     LAST  = BW'(BEATS - 1);
    localparam logic [3:0]        WS_L  = 4'(WAIT_STATES);
    localparam logic [DATA_W-1:0] BASE  = DATA_W'(BASE_ADDR);
    localparam logic [DATA_W-1:0] DEP_W = DATA_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t            state, nxt_state;
    logic [BW-1:0]     beat, nxt_beat;
    logic [3:0]        wcnt, nxt_wait;
    logic              op_wr, nxt_wr;
    logic [DATA_W-1:0] off_q, nxt_off;
    logic [DATA_W-1:0] wd_q, nxt_wd;
    logic [DATA_W-1:0] asm_q, asm_nxt;
    logic [DATA_W-1:0] sa_full;
    logic [SRAM_DW-1:0] nxt_slice;
    logic              req, in_err, hit, rd_hit;
    logic              acc_nxt, last_cyc;
    logic [DATA_W-1:0] in_off;
    logic [DATA_W-1:0] hit_data;

    assign req    = bus.mem_r_en | bus.mem_w_en;
    assign in_off = (bus.addr - BASE) >> 2;
    assign in_err = (bus.addr < BASE) || (in_off >= DEP_W);
    assign rd_hit = !bus.mem_w_en && hit;

    assign bus.ready = (state == IDLE && !req) || (state == DONE);

    always_comb begin
        nxt_state = state;
        nxt_beat  = beat;
        nxt_wait  = wcnt;
        nxt_wr    = op_wr;
        nxt_off   = off_q;
        nxt_wd    = wd_q;
        unique case (state)
            IDLE: begin
                if (req) begin
                    nxt_wr   = bus.mem_w_en;
                    nxt_off  = in_off;
                    nxt_wd   = bus.wdata;
                    nxt_beat = '0;
                    nxt_wait = '0;
                    nxt_state = (in_err || rd_hit) ? DONE : ACCESS;
                end
            end
            ACCESS: begin
                if (wcnt == WS_L) begin
                    nxt_wait = '0;
                    if (beat == LAST) nxt_state = DONE;
                    else              nxt_beat  = beat + 1'b1;
                end else begin
                    nxt_wait = wcnt + 4'd1;
                end
            end
            DONE:    nxt_state = IDLE;
            default: nxt_state = IDLE;
        endcase
        acc_nxt   = (nxt_state == ACCESS);
        last_cyc  = (state == ACCESS) && (wcnt == WS_L);
        sa_full   = nxt_off * DATA_W'(BEATS) + DATA_W'(nxt_beat);
        nxt_slice = nxt_wd[nxt_beat*SRAM_DW +: SRAM_DW];
    end

    // Current beat's SRAM slice merged into the partially assembled word.
    always_comb begin
        asm_nxt = asm_q;
        asm_nxt[beat*SRAM_DW +: SRAM_DW] = sram_dq_in;
    end

`ifdef READ_BUF_EN
    logic              buf_v;
    logic [DATA_W-1:0] buf_off;
    logic [DATA_W-1:0] buf_d;

    assign hit      = buf_v && (buf_off == in_off);
    assign hit_data = buf_d;

    // Buffer is only touched by completed accesses, never by aborted ones.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            buf_v   <= 1'b0;
            buf_off <= '0;
            buf_d   <= '0;
        end else if (last_cyc && beat == LAST) begin
            if (!op_wr) begin
                buf_v   <= 1'b1;
                buf_off <= off_q;
                buf_d   <= asm_nxt;
            end else if (buf_v && buf_off == off_q) begin
                buf_d <= wd_q;
            end
        end
    end
`else
    assign hit      = 1'b0;
    assign hit_data = '0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            beat         <= '0;
            wcnt         <= '0;
            op_wr        <= 1'b0;
            off_q        <= '0;
            wd_q         <= '0;
            asm_q        <= '0;
            bus.rdata    <= '0;
            bus.addr_err <= 1'b0;
            sram_addr    <= '0;
            sram_dq_out  <= '0;
            sram_dq_oe   <= 1'b0;
            sram_we_n    <= 1'b1;
            sram_oe_n    <= 1'b1;
        end else begin
            state <= nxt_state;
            beat  <= nxt_beat;
            wcnt  <= nxt_wait;
            op_wr <= nxt_wr;
            off_q <= nxt_off;
            wd_q  <= nxt_wd;

            bus.addr_err <= (state == IDLE) && req && in_err;

            // Strobes are registered from next-state so they are glitch-free;
            // we_n rises on the last wait cycle while addr/data stay put.
            sram_we_n   <= !(acc_nxt && nxt_wr && nxt_wait != WS_L);
            sram_oe_n   <= !(acc_nxt && !nxt_wr);
            sram_dq_oe  <= acc_nxt && nxt_wr;
            sram_dq_out <= (acc_nxt && nxt_wr) ? nxt_slice : '0;
            if (acc_nxt) sram_addr <= sa_full[SRAM_AW-1:0];

            if (last_cyc && !op_wr) begin
                asm_q <= asm_nxt;
                if (beat == LAST) bus.rdata <= asm_nxt;
            end

            if (state == IDLE && req) begin
                if (in_err)      bus.rdata <= '0;
                else if (rd_hit) bus.rdata <= hit_data;
            end
        end
    end
endmodule

// File: tb/tb_sram_mem_stage.sv
// Randomised self-checking bench for sram_mem_stage with an async SRAM model.
// Word-level reference memory predicts latency, rdata and addr_err.
module tb_sram_mem_stage;
    localparam int LAT_SRAM = 1 + 2 * (2 + 1);

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out;
    logic        sram_dq_oe;
    logic [15:0] sram_dq_in;
    logic        sram_we_n;
    logic        sram_oe_n;

    sram_mem_stage_if #(.DATA_W(32)) bus ();

    sram_mem_stage dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .sram_addr  (sram_addr),
        .sram_dq_out(sram_dq_out),
        .sram_dq_oe (sram_dq_oe),
        .sram_dq_in (sram_dq_in),
        .sram_we_n  (sram_we_n),
        .sram_oe_n  (sram_oe_n)
    );

    always #5 clk = ~clk;

    // Async SRAM: write latched on the rising we_n edge while data is driven.
    logic [15:0] sram [0:262143];
    logic        prev_we = 1'b1;
    assign sram_dq_in = !sram_oe_n ? sram[sram_addr] : 16'h0000;

    always @(negedge clk) begin
        if (!prev_we && sram_we_n && sram_dq_oe)
            sram[sram_addr] <= sram_dq_out;
        prev_we <= sram_we_n;
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model state
    logic [31:0] ref_mem [int unsigned];
    logic [31:0] model_rd = '0;
    bit          buf_v = 1'b0;
    logic [31:0] buf_off = '0;
    logic [31:0] buf_d = '0;

    // Expectations for the request in flight
    bit          chk_en = 1'b0;
    bit          pending = 1'b0;
    int          cnt = 0;
    int          exp_lat = 0;
    int          last_lat = 0;
    bit          exp_err = 1'b0;
    bit          exp_wr = 1'b0;
    bit          no_sram = 1'b0;
    logic [31:0] exp_rd = '0;

    initial begin
        forever begin
            @(negedge clk);
            #1;
            if (chk_en) begin
                if (pending) begin
                    if (cnt == exp_lat) begin
                        chk("ready_done", 32'(bus.ready), 32'd1);
                        chk("addr_err", 32'(bus.addr_err), 32'(exp_err));
                        chk("rdata", bus.rdata, exp_rd);
                        model_rd = exp_rd;
                        last_lat = cnt;
                        pending  = 1'b0;
                    end else begin
                        chk("ready_busy", 32'(bus.ready), 32'd0);
                        chk("err_low", 32'(bus.addr_err), 32'd0);
                        if (no_sram || cnt == 0) begin
                            chk("we_idle", 32'(sram_we_n), 32'd1);
                            chk("oe_idle", 32'(sram_oe_n), 32'd1);
                        end else if (exp_wr) begin
                            chk("oe_on_wr", 32'(sram_oe_n), 32'd1);
                        end else begin
                            chk("we_on_rd", 32'(sram_we_n), 32'd1);
                        end
                    end
                    cnt++;
                end else begin
                    chk("ready_idle", 32'(bus.ready), 32'd1);
                    chk("err_idle", 32'(bus.addr_err), 32'd0);
                    chk("rdata_hold", bus.rdata, model_rd);
                    chk("we_n_idle", 32'(sram_we_n), 32'd1);
                    chk("oe_n_idle", 32'(sram_oe_n), 32'd1);
                end
            end
        end
    end

    function automatic logic [31:0] ref_rd(input logic [31:0] off);
        return ref_mem.exists(off) ? ref_mem[off] : 32'h0;
    endfunction

    task automatic summary();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    endtask

    task automatic issue(input bit r, input bit w, input logic [31:0] a,
                         input logic [31:0] d);
        logic [31:0] off;
        bit          err;
        off = (a - 32'd1024) >> 2;
        err = (a < 32'd1024) || (off >= 32'd65536);
        exp_wr  = w;
        exp_err = err;
        exp_rd  = model_rd;
        if (err) begin
            exp_lat = 1;
            exp_rd  = '0;
            no_sram = 1'b1;
        end else if (w) begin
            exp_lat = LAT_SRAM;
            no_sram = 1'b0;
            ref_mem[off] = d;
            if (buf_v && buf_off == off) buf_d = d;
        end else begin
`ifdef READ_BUF_EN
            if (buf_v && buf_off == off) begin
                exp_lat = 1;
                no_sram = 1'b1;
                exp_rd  = buf_d;
            end else begin
                exp_lat = LAT_SRAM;
                no_sram = 1'b0;
                exp_rd  = ref_rd(off);
                buf_v   = 1'b1;
                buf_off = off;
                buf_d   = exp_rd;
            end
`else
            exp_lat = LAT_SRAM;
            no_sram = 1'b0;
            exp_rd  = ref_rd(off);
`endif
        end
        bus.mem_r_en = r;
        bus.mem_w_en = w;
        bus.addr     = a;
        bus.wdata    = d;
        cnt     = 0;
        pending = 1'b1;
        for (int i = 0; i < 40 && pending; i++) @(negedge clk);
        if (pending) begin
            errors++;
            $display("FAIL timeout: ready never rose for addr %h", a);
            summary();
            $fatal(1, "request timed out");
        end
    endtask

    task automatic idle(input int n);
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int          k;
        int          op;
        logic [31:0] a;
        for (int i = 0; i < 262144; i++) sram[i] = 16'h0000;
        bus.mem_r_en = 1'b0;
        bus.mem_w_en = 1'b0;
        bus.addr     = '0;
        bus.wdata    = '0;

        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(bus.ready), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk("idle_ready", 32'(bus.ready), 32'd1);
        chk("idle_rdata", bus.rdata, 32'd0);
        chk_en = 1'b1;
        @(negedge clk);

        issue(1'b0, 1'b1, 32'd1024, 32'hDEAD_BEEF);
        chk("lat_store", 32'(last_lat), 32'd7);
        chk("sram_w0", 32'(sram[0]), 32'h0000_BEEF);
        chk("sram_w1", 32'(sram[1]), 32'h0000_DEAD);
        issue(1'b1, 1'b0, 32'd1024, 32'h0);
        chk("lat_load", 32'(last_lat), 32'd7);
        chk("load_val", bus.rdata, 32'hDEAD_BEEF);

        issue(1'b1, 1'b0, 32'd1000, 32'h0);
        chk("lat_err_lo", 32'(last_lat), 32'd1);
        chk("rdata_err_lo", bus.rdata, 32'd0);
        issue(1'b1, 1'b0, 32'd1024 + 32'd4 * 32'd65536, 32'h0);
        chk("lat_err_hi", 32'(last_lat), 32'd1);

        issue(1'b1, 1'b1, 32'd1028, 32'h1234_5678);
        chk("lat_both", 32'(last_lat), 32'd7);
        idle(1);
        issue(1'b1, 1'b0, 32'd1028, 32'h0);
        chk("both_val", bus.rdata, 32'h1234_5678);

        issue(1'b1, 1'b0, 32'd1032, 32'h0);
        chk("lat_buf1", 32'(last_lat), 32'd7);
        issue(1'b1, 1'b0, 32'd1032, 32'h0);
`ifdef READ_BUF_EN
        chk("lat_buf2", 32'(last_lat), 32'd1);
`else
        chk("lat_buf2", 32'(last_lat), 32'd7);
`endif
        issue(1'b0, 1'b1, 32'd1032, 32'hA5A5_A5A5);
        issue(1'b1, 1'b0, 32'd1032, 32'h0);
        chk("buf_val", bus.rdata, 32'hA5A5_A5A5);
`ifdef READ_BUF_EN
        chk("lat_buf3", 32'(last_lat), 32'd1);
`endif

        // Reset during beat 1 of a store to word offset 5
        issue(1'b0, 1'b1, 32'd1044, 32'h1111_2222);
        idle(1);
        chk_en = 1'b0;
        bus.mem_w_en = 1'b1;
        bus.addr     = 32'd1044;
        bus.wdata    = 32'hAAAA_BBBB;
        repeat (5) @(negedge clk);
        #3;
        rst = 1'b0;
        bus.mem_w_en = 1'b0;
        #1;
        chk("mid_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_oe_n", 32'(sram_oe_n), 32'd1);
        chk("mid_dq_oe", 32'(sram_dq_oe), 32'd0);
        chk("mid_rdata", bus.rdata, 32'd0);
        chk("mid_ready", 32'(bus.ready), 32'd1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_w1", 32'(sram[11]), 32'h0000_1111);
        chk("mid_w0", 32'(sram[10]), 32'h0000_BBBB);
        ref_mem[32'd5] = 32'h1111_BBBB;
        model_rd = '0;
        buf_v    = 1'b0;
        chk_en   = 1'b1;
        issue(1'b1, 1'b0, 32'd1044, 32'h0);
        chk("mid_load", bus.rdata, 32'h1111_BBBB);

        for (int i = 0; i < 150; i++) begin
            k  = $urandom_range(0, 9);
            op = $urandom_range(0, 2);
            if (k == 0)
                a = 32'($urandom_range(0, 1023));
            else if (k == 1)
                a = 32'd1024 + 32'd4 * 32'd65536 + 32'($urandom_range(0, 4095));
            else if (k == 2)
                a = 32'd1024 + 32'd4 * 32'd65535 + 32'($urandom_range(0, 3));
            else if (k == 3)
                a = $urandom | 32'h8000_0000;
            else
                a = 32'd1024 + 32'd4 * 32'($urandom_range(0, 15))
                    + 32'($urandom_range(0, 3));
            issue(op != 1, op != 0, a, $urandom);
            if ($urandom_range(0, 2) == 0) idle($urandom_range(1, 2));
        end

        idle(2);
        summary();
        $finish;
    end
endmodule

// File: doc/sram_mem_stage.md
Name: sram_mem_stage

Overview:
- Parametrised successor to the single-cycle data memory in the MEM stage.
- Services pipeline load/store requests against an external asynchronous SRAM with programmable wait states.
- A 32-bit word is split into one or more SRAM beats.
- Drives a `ready` signal that the pipeline uses as a global freeze: all stages hold while `ready` = 0.

Parameters:
- DATA_W, 32, pipeline data and address width.
- SRAM_DW, 16, SRAM data bus width; must divide DATA_W; BEATS = DATA_W/SRAM_DW.
- SRAM_AW, 18, SRAM address width.
- WAIT_STATES, 2, extra cycles each beat is held on the SRAM bus (0..15).
- BASE_ADDR, 1024, byte address mapped to SRAM word 0.
- DEPTH, 65536, number of DATA_W words addressable.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_r_en  in  1  load request from EXE/MEM register.
- mem_w_en  in  1  store request.
- addr  in  DATA_W  byte address (ALU result).
- wdata  in  DATA_W  store data (Rm value).
- rdata  out  DATA_W  load data, valid while `ready` = 1 in DONE.
- ready  out  1  request complete / no request; 0 freezes pipeline.
- addr_err  out  1  one-cycle pulse on an out-of-range access.
- sram_addr  out  SRAM_AW  SRAM address.
- sram_dq_out  out  SRAM_DW  write data to SRAM.
- sram_dq_oe  out  1  tristate enable for sram_dq_out.
- sram_dq_in  in  SRAM_DW  read data from SRAM.
- sram_we_n  out  1  SRAM write strobe, active-low.
- sram_oe_n  out  1  SRAM output enable, active-low.

Behaviour:
- Reset: state IDLE; rdata = 0; sram_we_n = 1, sram_oe_n = 1, sram_dq_oe = 0; sram_addr = 0; addr_err = 0; beat and wait counters = 0.
- Reset asserted mid-access aborts the access immediately; no partial write completes after reset release.
- States: IDLE, ACCESS, DONE.
- ready (combinational) = (IDLE and no request) or DONE.
  - A request in IDLE drops `ready` in the same cycle.
- IDLE:
  - On mem_r_en|mem_w_en, latch addr, wdata and op.
  - Word offset = (addr − BASE_ADDR) >> 2; addr[1:0] ignored.
  - If addr < BASE_ADDR or offset ≥ DEPTH: go to DONE, pulse addr_err, rdata = 0, no SRAM strobes.
  - Otherwise go to ACCESS with beat = 0, wait = 0.
  - mem_r_en and mem_w_en both set: the write wins.
- ACCESS:
  - sram_addr = offset*BEATS + beat, truncated to SRAM_AW.
  - Write: sram_dq_out = wdata slice [beat*SRAM_DW +: SRAM_DW]; sram_dq_oe = 1; sram_we_n = 0 for all but the last wait cycle of the beat, so data and address stay stable around the rising edge of we_n.
  - Read: sram_oe_n = 0; sram_dq_in is sampled into slice beat on the last wait cycle of the beat.
  - Each beat lasts WAIT_STATES+1 cycles.
  - After the last beat, go to DONE.
  - Beat 0 is the least-significant slice.
- DONE:
  - ready = 1 for exactly one cycle; rdata holds the assembled word; go to IDLE.
  - The pipeline advances on this edge, so the request seen in the following IDLE cycle is a new instruction's.
- Latency for an in-range access, request to ready: 1 + BEATS*(WAIT_STATES+1) cycles. Defaults: 1 + 2*3 = 7.
- rdata holds its value until the next completed read.
- Inputs change while ACCESS: ignored, because values were latched in IDLE.

Optional Feature:
- Macro: READ_BUF_EN.
- Defined:
  - A one-entry read buffer holds the last word read and its offset, with a valid bit.
  - A read hitting the valid entry goes IDLE→DONE in 1 cycle with no SRAM strobes.
  - A write to the same offset updates the buffer with wdata.
  - Reset clears valid.
- Not defined: every in-range access goes through SRAM; no buffer logic is synthesised.

Test Plan:
- Reset then idle: after rst releases, with no request → ready = 1, sram_we_n = 1, sram_oe_n = 1, rdata = 0.
- Store then load at defaults: store 0xDEADBEEF to addr 1024 → ready low 7 cycles; SRAM word 0 = 0xBEEF, word 1 = 0xDEAD. Load from 1024 → ready after 7 cycles, rdata = 0xDEADBEEF.
- Out of range: load from addr 1000 → ready after 1 cycle, addr_err pulses, rdata = 0, no strobe. Same result for addr 1024+4*DEPTH.
- Reset mid-write: rst low during beat 1 of a store → outputs return to reset values at once; SRAM word 1 unchanged.
- Both enables set: mem_r_en = mem_w_en = 1, wdata 0x12345678 at 1028 → write performed; a later load returns 0x12345678.
- READ_BUF_EN: two loads from 1032 → first takes 7 cycles, second takes 1. After a store of 0xA5A5A5A5 to 1032, a load returns 0xA5A5A5A5 in 1 cycle.
